multi_player_logic: RTL and testbench

//  Per-frame game logic for NUM_PLAYERS cooks, clocked by vsync (one edge = one frame). Generalises

---
 rtl/multi_player_logic.sv | 189 ++++++++++++++++++
 tb/tb_multi_player_logic.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_logic.sv
// Per-frame cook logic: movement with wall/player collision, round-robin pick-up/drop through a
// single grid write port, and timed chopping. Every output is registered on the vsync edge.
module multi_player_logic #(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 13,
  parameter int GRID_H      = 8,
  parameter int TILE_SHIFT  = 5,
  parameter int SPEED       = 2,
  parameter int CHOP_FRAMES = 60
) (
  input  logic                                 vsync,
  input  logic                                 reset,
  input  logic [GRID_H-1:0][GRID_W-1:0][3:0]   object_grid,
  input  logic [NUM_PLAYERS-1:0]               left,
  input  logic [NUM_PLAYERS-1:0]               right,
  input  logic [NUM_PLAYERS-1:0]               up,
  input  logic [NUM_PLAYERS-1:0]               down,
  input  logic [NUM_PLAYERS-1:0]               chop,
  input  logic [NUM_PLAYERS-1:0]               carry,
  output logic [NUM_PLAYERS-1:0][3:0]          player_state,
  output logic [NUM_PLAYERS-1:0][1:0]          player_direction,
  output logic [NUM_PLAYERS-1:0][8:0]          player_loc_x,
  output logic [NUM_PLAYERS-1:0][8:0]          player_loc_y,
  output logic                                 grid_we,
  output logic [3:0]                           grid_wx,
  output logic [2:0]                           grid_wy,
  output logic [3:0]                           grid_wdata,
  output logic [NUM_PLAYERS-1:0]               chop_done
);
  localparam int TILE  = 1 << TILE_SHIFT;
  localparam int PIX_W = GRID_W << TILE_SHIFT;
  localparam int PIX_H = GRID_H << TILE_SHIFT;
  localparam int IW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int CNT_W = $clog2(CHOP_FRAMES + 1);

  typedef logic [GRID_H-1:0][GRID_W-1:0][3:0] grid_t;

  // A pixel blocks if it is off the play field or inside any non-floor tile.
  function automatic logic tile_blk(input grid_t g, input int px, input int py);
    if (px < 0 || py < 0 || px >= PIX_W || py >= PIX_H) return 1'b1;
    return g[RW'(py >>> TILE_SHIFT)][CW'(px >>> TILE_SHIFT)] != 4'd0;
  endfunction

  logic [IW-1:0]                    rr;
  logic [NUM_PLAYERS-1:0]           carry_q, pend;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0] chop_cnt;

  logic [NUM_PLAYERS-1:0]           face_ok, pick, req, chopping, carry_edge;
  logic [NUM_PLAYERS-1:0][3:0]      face_code, face_col;
  logic [NUM_PLAYERS-1:0][2:0]      face_row;

  always_comb begin
    int cx, cy;
    cx = 0;
    cy = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cx = (int'(player_loc_x[i]) + TILE / 2) >>> TILE_SHIFT;
      cy = (int'(player_loc_y[i]) + TILE / 2) >>> TILE_SHIFT;
      case (player_direction[i])
        2'd0:    cy = cy - 1;
        2'd1:    cy = cy + 1;
        2'd2:    cx = cx - 1;
        default: cx = cx + 1;
      endcase
      face_ok[i]    = cx >= 0 && cx < GRID_W && cy >= 0 && cy < GRID_H;
      face_col[i]   = 4'(cx);
      face_row[i]   = 3'(cy);
      face_code[i]  = face_ok[i] ? object_grid[RW'(cy)][CW'(cx)] : 4'd0;
      carry_edge[i] = carry[i] & ~carry_q[i];
      pick[i]       = player_state[i] == 4'd0 && face_code[i] >= 4'd3;
      req[i]        = (carry_edge[i] | pend[i]) & face_ok[i] &
                      (pick[i] | (player_state[i] != 4'd0 && face_code[i] == 4'd1));
      chopping[i]   = chop[i] & ~carry_edge[i] & (player_state[i] == 4'd0) &
                      (face_code[i] == 4'd2);
    end
  end

  logic [NUM_PLAYERS-1:0][8:0] x_nxt, y_nxt;
  logic [NUM_PLAYERS-1:0][1:0] dir_nxt;
  logic                        gnt_any;
  logic [IW-1:0]               gnt;

  // Players are resolved in rotating priority; px/py hold final positions for those already
  // processed and current positions for the rest.
  always_comb begin
    int px [NUM_PLAYERS];
    int py [NUM_PLAYERS];
    int nx, ny, ax, ay, bx, by;
    logic          blk;
    logic [IW-1:0] p;
    logic [1:0]    d;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      px[i] = int'(player_loc_x[i]);
      py[i] = int'(player_loc_y[i]);
    end
    dir_nxt = player_direction;
    gnt_any = 1'b0;
    gnt     = '0;
    nx = 0; ny = 0; ax = 0; ay = 0; bx = 0; by = 0;
    blk = 1'b0;
    p   = '0;
    d   = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      p = IW'((int'(rr) + k) % NUM_PLAYERS);
      if (req[p] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt     = p;
      end
      if (!chopping[p] && (up[p] | down[p] | left[p] | right[p])) begin
        d = up[p] ? 2'd0 : down[p] ? 2'd1 : left[p] ? 2'd2 : 2'd3;
        dir_nxt[p] = d;
        nx = px[p] + ((d == 2'd3) ? SPEED : (d == 2'd2) ? -SPEED : 0);
        ny = py[p] + ((d == 2'd1) ? SPEED : (d == 2'd0) ? -SPEED : 0);
        ax = nx; ay = ny; bx = nx; by = ny;
        case (d)
          2'd0:    bx = nx + TILE - 1;
          2'd1:    begin ay = ny + TILE - 1; by = ay; bx = nx + TILE - 1; end
          2'd2:    by = ny + TILE - 1;
          default: begin ax = nx + TILE - 1; bx = ax; by = ny + TILE - 1; end
        endcase
        blk = tile_blk(object_grid, ax, ay) | tile_blk(object_grid, bx, by);
        for (int j = 0; j < NUM_PLAYERS; j++)
          if (IW'(j) != p && nx - px[j] < TILE && px[j] - nx < TILE &&
              ny - py[j] < TILE && py[j] - ny < TILE)
            blk = 1'b1;
        if (!blk) begin
          px[p] = nx;
          py[p] = ny;
        end
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      x_nxt[i] = 9'(px[i]);
      y_nxt[i] = 9'(py[i]);
    end
  end

  always_ff @(posedge vsync) begin
    if (reset) begin
      rr         <= '0;
      carry_q    <= '0;
      pend       <= '0;
      chop_cnt   <= '0;
      chop_done  <= '0;
      grid_we    <= 1'b0;
      grid_wx    <= '0;
      grid_wy    <= '0;
      grid_wdata <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        player_loc_x[i]     <= 9'(TILE * (1 + 2 * i));
        player_loc_y[i]     <= 9'(TILE * (GRID_H - 2));
        player_direction[i] <= 2'd1;
        player_state[i]     <= 4'd0;
      end
    end else begin
      rr           <= (int'(rr) == NUM_PLAYERS - 1) ? '0 : rr + 1'b1;
      carry_q      <= carry;
      player_loc_x <= x_nxt;
      player_loc_y <= y_nxt;
      player_direction <= dir_nxt;
      grid_we      <= gnt_any;
      if (gnt_any) begin
        grid_wx    <= face_col[gnt];
        grid_wy    <= face_row[gnt];
        grid_wdata <= pick[gnt] ? 4'd1 : player_state[gnt];
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        // A losing request stays pending and is re-qualified against next frame's grid.
        pend[i] <= req[i] & ~(gnt_any && gnt == IW'(i));
        if (gnt_any && gnt == IW'(i))
          player_state[i] <= pick[i] ? face_code[i] : 4'd0;
        if (chopping[i]) begin
          if (chop_cnt[i] == CNT_W'(CHOP_FRAMES - 1)) begin
            chop_cnt[i]  <= '0;
            chop_done[i] <= 1'b1;
          end else begin
            chop_cnt[i]  <= chop_cnt[i] + 1'b1;
            chop_done[i] <= 1'b0;
          end
        end else begin
          chop_cnt[i]  <= '0;
          chop_done[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_player_logic.sv
// Bench for multi_player_logic: directed scenarios plus random play, all checked frame by frame
// against a rectangle-overlap reference model that also owns the object grid.
module tb_multi_player_logic;
  localparam int N = 2, GW = 13, GH = 8, T = 32, SPD = 2, CF = 60;
  localparam int PW = GW * T, PH = GH * T;

  logic vsync = 1'b0;
  logic reset = 1'b1;
  logic [GH-1:0][GW-1:0][3:0] object_grid;
  logic [N-1:0] left, right, up, down, chop, carry;
  logic [N-1:0][3:0] player_state;
  logic [N-1:0][1:0] player_direction;
  logic [N-1:0][8:0] player_loc_x, player_loc_y;
  logic        grid_we;
  logic [3:0]  grid_wx;
  logic [2:0]  grid_wy;
  logic [3:0]  grid_wdata;
  logic [N-1:0] chop_done;

  multi_player_logic dut (
    .vsync(vsync), .reset(reset), .object_grid(object_grid),
    .left(left), .right(right), .up(up), .down(down), .chop(chop), .carry(carry),
    .player_state(player_state), .player_direction(player_direction),
    .player_loc_x(player_loc_x), .player_loc_y(player_loc_y),
    .grid_we(grid_we), .grid_wx(grid_wx), .grid_wy(grid_wy), .grid_wdata(grid_wdata),
    .chop_done(chop_done)
  );

  always #5 vsync = ~vsync;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int g [GH][GW];
  int mx[N], my[N], md[N], ms[N], mprev[N], mpend[N], mcnt[N], mdone[N];
  int wxp[N], wyp[N];
  int mrr, mwe, mwx, mwy, mwd;

  task automatic pack_grid();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        object_grid[r][c] = 4'(g[r][c]);
  endtask

  task automatic clear_grid();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        g[r][c] = 0;
    pack_grid();
  endtask

  task automatic clear_in();
    left = '0; right = '0; up = '0; down = '0; chop = '0; carry = '0;
  endtask

  // Box at (ax,ay) is free if inside the field, overlapping no solid tile and no other player.
  function automatic bit spot_free(input int p, input int ax, input int ay);
    if (ax < 0 || ay < 0 || ax + T > PW || ay + T > PH) return 1'b0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        if (g[r][c] != 0 && ax < (c + 1) * T && c * T < ax + T && ay < (r + 1) * T && r * T < ay + T)
          return 1'b0;
    for (int j = 0; j < N; j++)
      if (j != p && ax < wxp[j] + T && wxp[j] < ax + T && ay < wyp[j] + T && wyp[j] < ay + T)
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      mx[p] = T * (1 + 2 * p); my[p] = T * (GH - 2); md[p] = 1; ms[p] = 0;
      mprev[p] = 0; mpend[p] = 0; mcnt[p] = 0; mdone[p] = 0;
    end
    mrr = 0; mwe = 0;
  endtask

  task automatic model_step();
    int fc[N], fr[N], code[N];
    bit edge_c[N], chp[N], req[N];
    int win, p, d;
    for (int i = 0; i < N; i++) begin
      fc[i] = (mx[i] + T / 2) / T + (md[i] == 3 ? 1 : md[i] == 2 ? -1 : 0);
      fr[i] = (my[i] + T / 2) / T + (md[i] == 1 ? 1 : md[i] == 0 ? -1 : 0);
      code[i] = (fc[i] >= 0 && fc[i] < GW && fr[i] >= 0 && fr[i] < GH) ? g[fr[i]][fc[i]] : -1;
      edge_c[i] = carry[i] && mprev[i] == 0;
      chp[i] = chop[i] && !edge_c[i] && ms[i] == 0 && code[i] == 2;
      req[i] = (edge_c[i] || mpend[i] != 0) &&
               ((ms[i] == 0 && code[i] >= 3) || (ms[i] != 0 && code[i] == 1));
      wxp[i] = mx[i]; wyp[i] = my[i];
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      p = (mrr + k) % N;
      if (req[p] && win < 0) win = p;
      if (!chp[p] && (up[p] || down[p] || left[p] || right[p])) begin
        d = up[p] ? 0 : down[p] ? 1 : left[p] ? 2 : 3;
        md[p] = d;
        if (spot_free(p, wxp[p] + (d == 3 ? SPD : d == 2 ? -SPD : 0),
                         wyp[p] + (d == 1 ? SPD : d == 0 ? -SPD : 0))) begin
          wxp[p] += (d == 3 ? SPD : d == 2 ? -SPD : 0);
          wyp[p] += (d == 1 ? SPD : d == 0 ? -SPD : 0);
        end
      end
    end
    mwe = (win >= 0);
    if (win >= 0) begin
      mwx = fc[win]; mwy = fr[win];
      mwd = (ms[win] == 0) ? 1 : ms[win];
      ms[win] = (ms[win] == 0) ? code[win] : 0;
    end
    for (int i = 0; i < N; i++) begin
      mpend[i] = (req[i] && i != win) ? 1 : 0;
      mprev[i] = carry[i];
      mx[i] = wxp[i]; my[i] = wyp[i];
      if (chp[i]) begin
        mcnt[i]++;
        mdone[i] = (mcnt[i] == CF) ? 1 : 0;
        if (mcnt[i] == CF) mcnt[i] = 0;
      end else begin
        mcnt[i] = 0; mdone[i] = 0;
      end
    end
    mrr = (mrr + 1) % N;
  endtask

  task automatic check_all();
    for (int p = 0; p < N; p++) begin
      chk($sformatf("x%0d", p), int'(player_loc_x[p]), mx[p]);
      chk($sformatf("y%0d", p), int'(player_loc_y[p]), my[p]);
      chk($sformatf("dir%0d", p), int'(player_direction[p]), md[p]);
      chk($sformatf("state%0d", p), int'(player_state[p]), ms[p]);
      chk($sformatf("done%0d", p), int'(chop_done[p]), mdone[p]);
    end
    chk("we", int'(grid_we), mwe);
    if (mwe != 0) begin
      chk("wx", int'(grid_wx), mwx);
      chk("wy", int'(grid_wy), mwy);
      chk("wdata", int'(grid_wdata), mwd);
    end
  endtask

  // One frame: model predicts, DUT clocks, outputs compared, grid owner applies the write.
  task automatic step(input bit rst);
    reset = rst;
    if (rst) model_reset(); else model_step();
    @(posedge vsync);
    #1;
    check_all();
    if (mwe != 0) begin
      g[mwy][mwx] = mwd;
      pack_grid();
    end
  endtask

  initial begin
    int v;
    clear_in();
    clear_grid();
    step(1); step(1);
    chk("rst_x0", int'(player_loc_x[0]), 32);
    chk("rst_x1", int'(player_loc_x[1]), 96);
    chk("rst_y0", int'(player_loc_y[0]), 192);
    chk("rst_y1", int'(player_loc_y[1]), 192);
    chk("rst_dir0", int'(player_direction[0]), 1);
    chk("rst_state1", int'(player_state[1]), 0);
    chk("rst_we", int'(grid_we), 0);

    // Free walk, then a board tile directly to the right stops the step
    right = 2'b01; repeat (10) step(0);
    chk("walk_x", int'(player_loc_x[0]), 52);
    right = '0; step(1);
    g[6][2] = 2; pack_grid();
    right = 2'b01; repeat (3) step(0);
    chk("wall_x", int'(player_loc_x[0]), 32);
    chk("wall_dir", int'(player_direction[0]), 3);

    // Head-on approach stops with boxes touching
    clear_in(); clear_grid(); step(1);
    right = 2'b01; left = 2'b10; repeat (12) step(0);
    chk("meet_x0", int'(player_loc_x[0]), 48);
    chk("meet_gap", int'(player_loc_x[1]) - int'(player_loc_x[0]), 32);

    // Contended pick-up of one item, then drop back onto the emptied counter
    clear_in(); clear_grid(); g[6][2] = 5; pack_grid(); step(1);
    right = 2'b01; left = 2'b10; step(0);
    clear_in(); step(0);
    carry = 2'b11; step(0);
    chk("pick_s0", int'(player_state[0]), 5);
    chk("pick_s1", int'(player_state[1]), 0);
    chk("pick_we", int'(grid_we), 1);
    chk("pick_wd", int'(grid_wdata), 1);
    step(0);
    chk("lose_we", int'(grid_we), 0);
    chk("lose_s1", int'(player_state[1]), 0);
    carry = '0; step(0);
    carry = 2'b01; step(0);
    chk("drop_s0", int'(player_state[0]), 0);
    chk("drop_wd", int'(grid_wdata), 5);

    // Chopping: full run pulses once, early release never pulses
    clear_in(); clear_grid(); g[6][2] = 2; pack_grid(); step(1);
    right = 2'b01; step(0); right = '0;
    chop = 2'b01;
    for (int f = 1; f <= 60; f++) begin step(0); chk("chop60", int'(chop_done[0]), int'(f == 60)); end
    chop = '0; step(0);
    chop = 2'b01;
    for (int f = 1; f <= 30; f++) begin step(0); chk("chop30", int'(chop_done[0]), 0); end
    chop = '0;
    for (int f = 1; f <= 40; f++) begin step(0); chk("chop_rel", int'(chop_done[0]), 0); end

    // Reset in the middle of a chop restarts the count from zero
    right = 2'b01; step(0); right = '0;
    chop = 2'b01; repeat (40) step(0);
    step(1);
    chk("rst_chop_done", int'(chop_done[0]), 0);
    chk("rst_chop_dir", int'(player_direction[0]), 1);
    chop = '0; right = 2'b01; step(0); right = '0;
    chop = 2'b01;
    for (int f = 1; f <= 60; f++) begin step(0); chk("rechop", int'(chop_done[0]), int'(f == 60)); end

    // Random play on a kitchen with stations in the top rows
    clear_in(); clear_grid();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < GW; c++) begin
        v = $urandom_range(0, 99);
        g[r][c] = (v < 40) ? 0 : (v < 65) ? 1 : (v < 80) ? 2 : $urandom_range(3, 15);
      end
    pack_grid();
    step(1);
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < N; p++) begin
        up[p]    = ($urandom_range(0, 3) == 0);
        down[p]  = ($urandom_range(0, 3) == 0);
        left[p]  = ($urandom_range(0, 3) == 0);
        right[p] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 79) == 0) chop[p] = ~chop[p];
        if ($urandom_range(0, 5) == 0) carry[p] = ~carry[p];
      end
      step($urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
